// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: operands, immediate, PC, instruction and aging Tnew.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_reg #(
    parameter int WIDTH  = 32,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              En,
    input  logic              Clr,
    input  logic [WIDTH-1:0]  Instr_D,
    input  logic [WIDTH-1:0]  PC_D,
    input  logic [WIDTH-1:0]  RS_Data_D,
    input  logic [WIDTH-1:0]  RT_Data_D,
    input  logic [WIDTH-1:0]  Ext_D,
    input  logic [TNEW_W-1:0] Tnew_D,
    output logic [WIDTH-1:0]  Instr_E,
    output logic [WIDTH-1:0]  PC_E,
    output logic [WIDTH-1:0]  RS_Data_E,
    output logic [WIDTH-1:0]  RT_Data_E,
    output logic [WIDTH-1:0]  Ext_E,
    output logic [TNEW_W-1:0] Tnew_E,
    output logic              Valid_E
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]       Bubble_Cnt
`endif
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Instr_E   <= '0;
            PC_E      <= '0;
            RS_Data_E <= '0;
            RT_Data_E <= '0;
            Ext_E     <= '0;
            Tnew_E    <= '0;
            Valid_E   <= 1'b0;
        end else if (Clr) begin
            Instr_E   <= '0;
            PC_E      <= '0;
            RS_Data_E <= '0;
            RT_Data_E <= '0;
            Ext_E     <= '0;
            Tnew_E    <= '0;
            Valid_E   <= 1'b0;
        end else if (En) begin
            Instr_E   <= Instr_D;
            PC_E      <= PC_D;
            RS_Data_E <= RS_Data_D;
            RT_Data_E <= RT_Data_D;
            Ext_E     <= Ext_D;
            Tnew_E    <= Tnew_D;
            Valid_E   <= 1'b1;
        end else if (Tnew_E != '0) begin
            // a frozen E stage still lets the producer's result mature
            Tnew_E <= Tnew_E - TNEW_W'(1);
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Bubble_Cnt <= '0;
        end else if (Clr) begin
            Bubble_Cnt <= Bubble_Cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg against a behavioural model.
// Exercises reset, load, bubble, hold/aging, async reset and optional counter.
module tb_id_ex_reg;

    localparam int W  = 32;
    localparam int TW = 2;
    localparam int OW = 5 * W + TW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          En = 1'b0;
    logic          Clr = 1'b0;
    logic [W-1:0]  Instr_D = '0;
    logic [W-1:0]  PC_D = '0;
    logic [W-1:0]  RS_Data_D = '0;
    logic [W-1:0]  RT_Data_D = '0;
    logic [W-1:0]  Ext_D = '0;
    logic [TW-1:0] Tnew_D = '0;
    logic [W-1:0]  Instr_E;
    logic [W-1:0]  PC_E;
    logic [W-1:0]  RS_Data_E;
    logic [W-1:0]  RT_Data_E;
    logic [W-1:0]  Ext_E;
    logic [TW-1:0] Tnew_E;
    logic          Valid_E;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0]   Bubble_Cnt;
`endif

    int nt = 0;
    int nf = 0;

    // model of the E-stage contents
    int unsigned m_instr, m_pc, m_rs, m_rt, m_ext;
    int          m_tnew;
    bit          m_valid;
    int unsigned m_bcnt;

    id_ex_reg #(.WIDTH(W), .TNEW_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .En        (En),
        .Clr       (Clr),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
        .RS_Data_D (RS_Data_D),
        .RT_Data_D (RT_Data_D),
        .Ext_D     (Ext_D),
        .Tnew_D    (Tnew_D),
        .Instr_E   (Instr_E),
        .PC_E      (PC_E),
        .RS_Data_E (RS_Data_E),
        .RT_Data_E (RT_Data_E),
        .Ext_E     (Ext_E),
        .Tnew_E    (Tnew_E),
        .Valid_E   (Valid_E)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .Bubble_Cnt(Bubble_Cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] obs();
        return {Instr_E, PC_E, RS_Data_E, RT_Data_E, Ext_E, Tnew_E, Valid_E};
    endfunction

    function automatic logic [OW-1:0] expv();
        logic [TW-1:0] t;
        t = TW'(m_tnew);
        return {m_instr, m_pc, m_rs, m_rt, m_ext, t, m_valid};
    endfunction

    task automatic model_clear();
        m_instr = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_ext = 0;
        m_tnew = 0; m_valid = 0;
    endtask

    // advance one edge and apply the register's rules to the model
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
            m_bcnt = 0;
        end else if (Clr) begin
            model_clear();
            m_bcnt = m_bcnt + 1;
        end else if (En) begin
            m_instr = Instr_D; m_pc = PC_D; m_rs = RS_Data_D;
            m_rt = RT_Data_D; m_ext = Ext_D; m_tnew = Tnew_D;
            m_valid = 1;
        end else begin
            m_tnew = (m_tnew > 0) ? m_tnew - 1 : 0;
        end
        #1;
    endtask

    task automatic rand_d();
        Instr_D = $urandom; PC_D = $urandom; RS_Data_D = $urandom;
        RT_Data_D = $urandom; Ext_D = $urandom;
        Tnew_D = TW'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        rand_d(); En = 1'b1; Clr = 1'b0;
        #1;
        model_clear();
        m_bcnt = 0;
        nt++;
        if (obs() !== expv()) begin
            nf++;
            $display("FAIL reset_async got=%h exp=%h", obs(), expv());
        end
        for (int i = 0; i < 2; i++) begin
            rand_d();
            tick();
            nt++;
            if (obs() !== expv()) begin
                nf++;
                $display("FAIL reset_hold got=%h exp=%h", obs(), expv());
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_load();
        En = 1'b1; Clr = 1'b0;
        Instr_D = 32'h3C011234; PC_D = 32'h00003004; Ext_D = 32'hFFFF8000;
        RS_Data_D = 32'h11111111; RT_Data_D = 32'h22222222; Tnew_D = 2'd1;
        tick();
        nt++;
        if (Instr_E !== 32'h3C011234 || PC_E !== 32'h00003004 ||
            Ext_E !== 32'hFFFF8000 || Tnew_E !== 2'd1 || Valid_E !== 1'b1) begin
            nf++;
            $display("FAIL load got=%h exp=%h", obs(), expv());
        end
        nt++;
        if (obs() !== expv()) begin
            nf++;
            $display("FAIL load_model got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_bubble();
        En = 1'b1; Clr = 1'b0; rand_d(); PC_D = 32'h3008;
        tick();
        nt++;
        if (PC_E !== 32'h3008 || Valid_E !== 1'b1) begin
            nf++;
            $display("FAIL bubble_pre got=%h exp=%h", obs(), expv());
        end
        Clr = 1'b1; rand_d();
        tick();
        nt++;
        if (obs() !== '0) begin
            nf++;
            $display("FAIL bubble got=%h exp=0", obs());
        end
        Clr = 1'b0; rand_d();
        tick();
        nt++;
        if (obs() !== expv() || Valid_E !== 1'b1) begin
            nf++;
            $display("FAIL bubble_reload got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_hold_aging();
        logic [TW-1:0] seq [3];
        seq[0] = 2'd1; seq[1] = 2'd0; seq[2] = 2'd0;
        En = 1'b1; Clr = 1'b0; rand_d();
        Tnew_D = 2'd2; RS_Data_D = 32'hDEADBEEF;
        tick();
        nt++;
        if (Tnew_E !== 2'd2 || RS_Data_E !== 32'hDEADBEEF) begin
            nf++;
            $display("FAIL hold_load got=%h exp=%h", obs(), expv());
        end
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            tick();
            nt++;
            if (RS_Data_E !== 32'hDEADBEEF || Valid_E !== 1'b1 ||
                Tnew_E !== seq[i] || obs() !== expv()) begin
                nf++;
                $display("FAIL hold_age%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        // a held bubble stays a bubble
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_d();
            tick();
            nt++;
            if (obs() !== '0) begin
                nf++;
                $display("FAIL bubble_held got=%h exp=0", obs());
            end
        end
    endtask

    task automatic test_clr_vs_en();
        En = 1'b1; Clr = 1'b0; rand_d(); Tnew_D = 2'd3;
        tick();
        En = 1'b0; Clr = 1'b1; rand_d();
        tick();
        nt++;
        if (obs() !== '0 || Valid_E !== 1'b0) begin
            nf++;
            $display("FAIL clr_vs_en got=%h exp=0", obs());
        end
        Clr = 1'b0;
    endtask

    task automatic test_async_reset();
        En = 1'b1; Clr = 1'b0; rand_d(); Tnew_D = 2'd3;
        tick();
        En = 1'b0; rand_d();
        #2;
        reset = 1'b1;
        #1;
        nt++;
        if (obs() !== '0) begin
            nf++;
            $display("FAIL async_reset got=%h exp=0", obs());
        end
        tick();
        reset = 1'b0;
        En = 1'b1; rand_d();
        tick();
        nt++;
        if (obs() !== expv() || Valid_E !== 1'b1) begin
            nf++;
            $display("FAIL post_reset got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_d();
            En  = ($urandom_range(0, 3) != 0);
            Clr = ($urandom_range(0, 5) == 0);
            tick();
            nt++;
            if (obs() !== expv()) begin
                nf++;
                $display("FAIL random%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        En = 1'b0; Clr = 1'b0;
    endtask

`ifdef ID_EX_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        Clr = 1'b1;
        repeat (5) begin rand_d(); En = $urandom_range(0, 1); tick(); end
        Clr = 1'b0; En = 1'b1;
        repeat (3) begin rand_d(); tick(); end
        nt++;
        if (Bubble_Cnt !== 32'(m_bcnt) || Bubble_Cnt !== 32'd5) begin
            nf++;
            $display("FAIL bcnt_count got=%0d exp=5", Bubble_Cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        nt++;
        if (Bubble_Cnt !== 32'd0) begin
            nf++;
            $display("FAIL bcnt_reset got=%0d exp=0", Bubble_Cnt);
        end
        tick();
        reset = 1'b0;
        force dut.Bubble_Cnt = 32'hFFFFFFFF;
        #1;
        release dut.Bubble_Cnt;
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        nt++;
        if (Bubble_Cnt !== 32'd0) begin
            nf++;
            $display("FAIL bcnt_wrap got=%h exp=0", Bubble_Cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_bubble();
        test_hold_aging();
        test_clr_vs_en();
        test_async_reset();
        test_random();
`ifdef ID_EX_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the five-stage MIPS core.
- Sits directly downstream of the immediate extender and the GRF read ports. Captures the extended immediate, both register operands, the PC and the instruction word, and presents them to the EX stage (ALU, mult/div).
- Also carries the producer's Tnew for hazard forwarding and ages it while the E stage is frozen.
- Supports bubble insertion (clear) and hold (stall of E, e.g. mult/div busy).

Parameters:
- WIDTH, 32, datapath width of PC, instruction, operand and immediate fields.
- TNEW_W, 2, width of the Tnew field.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- En  input  1  load enable; 0 = hold E-stage contents.
- Clr  input  1  bubble insert; clears the register at the next edge.
- Instr_D  input  WIDTH  D-stage instruction word.
- PC_D  input  WIDTH  D-stage PC.
- RS_Data_D  input  WIDTH  forwarded rs operand from D.
- RT_Data_D  input  WIDTH  forwarded rt operand from D.
- Ext_D  input  WIDTH  extended immediate from the extender output.
- Tnew_D  input  TNEW_W  cycles until the result is ready, counted from E entry.
- Instr_E  output  WIDTH  registered instruction.
- PC_E  output  WIDTH  registered PC.
- RS_Data_E  output  WIDTH  registered rs operand.
- RT_Data_E  output  WIDTH  registered rt operand.
- Ext_E  output  WIDTH  registered immediate.
- Tnew_E  output  TNEW_W  current Tnew of the E-stage instruction.
- Valid_E  output  1  1 = real instruction in E, 0 = bubble.

Behaviour:
- Reset:
  - While reset=1, all outputs are 0 immediately, not waiting for a clock edge. Instr_E=0 is a nop and Valid_E=0.
  - Reset deassertion takes effect at the next rising edge of clk. The first edge with reset=0 evaluates the normal priority.
- Priority at each rising edge: reset > Clr > En.
  - Clr=1: all data outputs go to 0, Tnew_E=0, Valid_E=0, regardless of En.
  - Clr=0, En=1: load. Every *_E output takes its *_D input, Valid_E=1. Latency is exactly 1 cycle.
  - Clr=0, En=0: hold. Instr_E, PC_E, RS_Data_E, RT_Data_E, Ext_E and Valid_E are unchanged.
- Tnew aging while held: Tnew_E = Tnew_E-1 if Tnew_E>0, else it stays 0. It saturates at 0 and never wraps.
- No combinational path from any input to any output. All outputs are driven directly from flops.
- Ext_D is stored bit-exact. No re-extension or width change happens in this stage.
- Clr and En both 1: Clr wins and a bubble is inserted.
- Reset asserted mid-hold: outputs clear asynchronously and the hold state is discarded.
- Bubble held (Valid_E=0, En=0): it stays a bubble and Tnew_E stays 0.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - Adds output Bubble_Cnt (32 bits).
  - Counts the rising edges at which Clr=1 and reset=0. Wraps from 0xFFFFFFFF to 0.
  - Cleared asynchronously by reset.
  - Unaffected by En.
- Not defined: the port and counter are absent and there is no other change in behaviour.

Test Plan:
- Reset and load:
  - Stimulus: reset=1 for 2 cycles with arbitrary inputs, then release. Next edge: En=1, Clr=0, Instr_D=0x3C011234, PC_D=0x00003004, Ext_D=0xFFFF8000, Tnew_D=1.
  - Response: all outputs 0 during reset. One cycle after the load edge, Instr_E=0x3C011234, PC_E=0x00003004, Ext_E=0xFFFF8000, Tnew_E=1, Valid_E=1.
- Bubble insertion:
  - Stimulus: E holds valid PC_E=0x3008; assert Clr=1 with En=1 for one edge.
  - Response: all *_E=0, Valid_E=0, Tnew_E=0. Next load restores normal capture.
- Hold with aging:
  - Stimulus: load Tnew_D=2, RS_Data_D=0xDEADBEEF, then En=0 for 3 edges while D inputs change.
  - Response: RS_Data_E stays 0xDEADBEEF and Valid_E stays 1. Tnew_E goes 2→1→0→0.
- Clr versus En conflict:
  - Stimulus: Clr=1 and En=0 while E holds a valid instruction.
  - Response: bubble inserted (Valid_E=0), not held.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges while E is valid.
  - Response: outputs go to 0 within the same cycle, before the next edge.
- With ID_EX_BUBBLE_CNT_EN:
  - Stimulus: 5 Clr edges, 3 load edges, then reset.
  - Response: Bubble_Cnt=5 before reset and 0 after. Preload the counter to 0xFFFFFFFF via force; one more Clr gives 0.
